seq_det_ctrl: RTL and testbench

Run-time programmable serial sequence detector with a control FSM. The pattern (1..MAX_LEN bits), length and overlap mode are loaded through a config strobe. The run is armed by start and ended by abort or by reaching a match-count target. A Mealy match output flags each hit, and a saturating counter tallies hits. It replaces the fixed-pattern detectors when a pattern must change without re-synthesis.

---
 rtl/seq_det_ctrl.sv | 158 +++++++++++++++
 tb/tb_seq_det_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Purpose: run-time programmable serial sequence detector with IDLE/RUN/DONE control FSM.
// Latency: match is combinational with the qualifying bit; busy/done/match_count/cfg_err update on the next clk.
// Backpressure: none; in_valid qualifies each bit and the block always accepts it.
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    input  logic               in,
    output logic               match,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_nxt;

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;

    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic               is_run;
    logic               arm;
    logic               cfg_ok;
    logic               fill_ok;
    logic               hit_target;
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] len_mask;
    logic [CNT_W:0]     cnt_inc;

    assign is_run  = (state == S_RUN);
    // start is only honoured outside RUN, and abort on the same cycle cancels it
    assign arm     = (state != S_RUN) && start && !abort;
    assign cfg_ok  = cfg_we && (state != S_RUN) && (cfg_len != '0)
                     && (cfg_len <= LEN_W'(MAX_LEN));

    // newest bit sits at position 0, oldest at len-1
    assign cand    = {hist_q[MAX_LEN-2:0], in};
    // fill >= len-1 written as fill+1 >= len so len=1 needs no underflow guard
    assign fill_ok = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};

    // select the low len bits of pattern and candidate
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign match = in_valid && is_run && !abort && fill_ok
                   && ((cand & len_mask) == (pat_q & len_mask));

    assign cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign hit_target = match && (tgt_q != '0) && (cnt_inc == {1'b0, tgt_q});

    // next-state decode; abort outranks both start and a terminal match
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (arm) state_nxt = S_RUN;
            S_RUN: begin
                if (abort)           state_nxt = S_IDLE;
                else if (hit_target) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // state register and registered status flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt == S_RUN);
            done_q <= (state_nxt == S_DONE);
            err_q  <= cfg_we && !cfg_ok;
        end
    end

    // config registers; all fields load together on an accepted write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pat_q <= {{(MAX_LEN-3){1'b0}}, 3'b101};
            len_q <= LEN_W'(3);
            ovl_q <= 1'b0;
            tgt_q <= '0;
        end else if (cfg_ok) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            ovl_q <= cfg_overlap;
            tgt_q <= cfg_target;
        end
    end

    // shift history on valid bits; non-overlap restarts the window after a hit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (arm) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (is_run && in_valid && !abort) begin
            if (match && !ovl_q) begin
                hist_q <= '0;
                fill_q <= '0;
            end else begin
                hist_q <= cand;
                if (fill_q != LEN_W'(MAX_LEN)) fill_q <= fill_q + LEN_W'(1);
            end
        end
    end

    // saturating hit counter, cleared only by start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (arm) begin
            cnt_q <= '0;
        end else if (match && !(&cnt_q)) begin
            cnt_q <= cnt_inc[CNT_W-1:0];
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = err_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Purpose: self-checking bench for seq_det_ctrl using per-cycle vector rows and an expectation queue.
// Latency: each row is driven on the falling edge and checked 3 ns later, before the next rising edge.
// Backpressure: not applicable; the DUT has no ready signal.
module tb_seq_det_ctrl;

    logic       clk;
    logic       rstn;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_target;
    logic       start;
    logic       abort;
    logic       in_valid;
    logic       din;
    logic       match;
    logic       busy;
    logic       done;
    logic [7:0] match_count;
    logic       cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    // one cycle of stimulus plus the outputs expected during that cycle
    typedef struct {
        logic       we;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov;
        logic [7:0] tgt;
        logic       st;
        logic       ab;
        logic       iv;
        logic       din;
        logic       m;
        logic       b;
        logic       d;
        logic [7:0] cnt;
        logic       e;
    } row_t;

    row_t vec[$];
    row_t sb[$];

    seq_det_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .in_valid    (in_valid),
        .in          (din),
        .match       (match),
        .busy        (busy),
        .done        (done),
        .match_count (match_count),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data/control row, no config write
    function automatic row_t io(input logic st, input logic ab, input logic iv, input logic d_in,
                                input logic m, input logic b, input logic d, input logic [7:0] cnt,
                                input logic e);
        row_t r;
        r.we = 1'b0; r.pat = 8'h00; r.len = 4'd0; r.ov = 1'b0; r.tgt = 8'h00;
        r.st = st; r.ab = ab; r.iv = iv; r.din = d_in;
        r.m = m; r.b = b; r.d = d; r.cnt = cnt; r.e = e;
        return r;
    endfunction

    // config-write row, optionally with start in the same cycle
    function automatic row_t cf(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                                input logic [7:0] tgt, input logic st,
                                input logic m, input logic b, input logic d, input logic [7:0] cnt,
                                input logic e);
        row_t r;
        r = io(st, 1'b0, 1'b0, 1'b0, m, b, d, cnt, e);
        r.we = 1'b1; r.pat = pat; r.len = len; r.ov = ov; r.tgt = tgt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // drive one row on the falling edge, queue its expectation, compare before the rising edge
    task automatic step(input row_t r, input string tag);
        row_t x;
        @(negedge clk);
        cfg_we = r.we; cfg_pattern = r.pat; cfg_len = r.len; cfg_overlap = r.ov; cfg_target = r.tgt;
        start = r.st; abort = r.ab; in_valid = r.iv; din = r.din;
        sb.push_back(r);
        #3;
        x = sb.pop_front();
        chk({tag, " match"},       {7'd0, match},   {7'd0, x.m});
        chk({tag, " busy"},        {7'd0, busy},    {7'd0, x.b});
        chk({tag, " done"},        {7'd0, done},    {7'd0, x.d});
        chk({tag, " match_count"}, match_count,     x.cnt);
        chk({tag, " cfg_err"},     {7'd0, cfg_err}, {7'd0, x.e});
    endtask

    initial begin
        rstn = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_target = '0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; din = 1'b0;

        // reset state: idle, valid bit present but no run -> nothing happens
        vec.push_back(io(0,0,1,1, 0,0,0,8'd0,0));
        // default 101, non-overlap: stream 1,0,1,0,1 hits on bit 3 only
        vec.push_back(io(1,0,0,0, 0,0,0,8'd0,0));
        vec.push_back(io(0,0,1,1, 0,1,0,8'd0,0));
        vec.push_back(io(0,0,1,0, 0,1,0,8'd0,0));
        vec.push_back(io(0,0,1,1, 1,1,0,8'd0,0));
        vec.push_back(io(0,0,1,0, 0,1,0,8'd1,0));
        vec.push_back(io(0,0,1,1, 0,1,0,8'd1,0));
        vec.push_back(io(0,0,0,0, 0,1,0,8'd1,0));
        // abort, then overlap 101 loaded together with start: hits on bits 3 and 5
        vec.push_back(io(0,1,0,0, 0,1,0,8'd1,0));
        vec.push_back(cf(8'b101,4'd3,1,8'd0,1, 0,0,0,8'd1,0));
        vec.push_back(io(0,0,1,1, 0,1,0,8'd0,0));
        vec.push_back(io(0,0,1,0, 0,1,0,8'd0,0));
        vec.push_back(io(0,0,1,1, 1,1,0,8'd0,0));
        vec.push_back(io(0,0,1,0, 0,1,0,8'd1,0));
        vec.push_back(io(0,0,1,1, 1,1,0,8'd1,0));
        vec.push_back(io(0,0,0,0, 0,1,0,8'd2,0));
        // 110, target 2: hits on bits 3 and 6, then DONE ignores input and abort
        vec.push_back(io(0,1,0,0, 0,1,0,8'd2,0));
        vec.push_back(cf(8'b110,4'd3,0,8'd2,0, 0,0,0,8'd2,0));
        vec.push_back(io(1,0,0,0, 0,0,0,8'd2,0));
        vec.push_back(io(0,0,1,1, 0,1,0,8'd0,0));
        vec.push_back(io(0,0,1,1, 0,1,0,8'd0,0));
        vec.push_back(io(0,0,1,0, 1,1,0,8'd0,0));
        vec.push_back(io(0,0,1,1, 0,1,0,8'd1,0));
        vec.push_back(io(0,0,1,1, 0,1,0,8'd1,0));
        vec.push_back(io(0,0,1,0, 1,1,0,8'd1,0));
        vec.push_back(io(0,0,1,1, 0,0,1,8'd2,0));
        vec.push_back(io(0,1,1,0, 0,0,1,8'd2,0));
        vec.push_back(io(1,0,0,0, 0,0,1,8'd2,0));
        vec.push_back(io(0,0,0,0, 0,1,0,8'd0,0));
        // 101 with two invalid cycles between bits (in held high while invalid)
        vec.push_back(io(0,1,0,0, 0,1,0,8'd0,0));
        vec.push_back(cf(8'b101,4'd3,0,8'd0,1, 0,0,0,8'd0,0));
        vec.push_back(io(0,0,1,1, 0,1,0,8'd0,0));
        vec.push_back(io(0,0,0,1, 0,1,0,8'd0,0));
        vec.push_back(io(0,0,0,1, 0,1,0,8'd0,0));
        vec.push_back(io(0,0,1,0, 0,1,0,8'd0,0));
        vec.push_back(io(0,0,0,1, 0,1,0,8'd0,0));
        vec.push_back(io(0,0,0,1, 0,1,0,8'd0,0));
        vec.push_back(io(0,0,1,1, 1,1,0,8'd0,0));
        vec.push_back(io(0,0,0,1, 0,1,0,8'd1,0));
        // rejected writes: during RUN, len=0, len=9; 101 still detected afterwards
        vec.push_back(cf(8'b111,4'd3,1,8'd0,0, 0,1,0,8'd1,0));
        vec.push_back(io(0,1,0,0, 0,1,0,8'd1,1));
        vec.push_back(cf(8'b111,4'd0,1,8'd0,0, 0,0,0,8'd1,0));
        vec.push_back(cf(8'b111,4'd9,1,8'd0,0, 0,0,0,8'd1,1));
        vec.push_back(io(0,0,0,0, 0,0,0,8'd1,1));
        vec.push_back(io(1,0,0,0, 0,0,0,8'd1,0));
        vec.push_back(io(0,0,1,1, 0,1,0,8'd0,0));
        vec.push_back(io(0,0,1,0, 0,1,0,8'd0,0));
        vec.push_back(io(0,0,1,1, 1,1,0,8'd0,0));
        // abort (with start) on a would-be hit: no match, back to IDLE, count kept
        vec.push_back(io(0,0,1,1, 0,1,0,8'd1,0));
        vec.push_back(io(0,0,1,0, 0,1,0,8'd1,0));
        vec.push_back(io(1,1,1,1, 0,1,0,8'd1,0));
        vec.push_back(io(0,0,1,1, 0,0,0,8'd1,0));
        vec.push_back(io(0,1,0,0, 0,0,0,8'd1,0));
        // len=1: every valid 1 hits; start during RUN does not clear the count
        vec.push_back(cf(8'h01,4'd1,0,8'd0,1, 0,0,0,8'd1,0));
        vec.push_back(io(0,0,1,1, 1,1,0,8'd0,0));
        vec.push_back(io(1,0,1,0, 0,1,0,8'd1,0));
        vec.push_back(io(0,0,1,1, 1,1,0,8'd1,0));
        vec.push_back(io(0,0,1,1, 1,1,0,8'd2,0));

        repeat (3) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < vec.size(); i++) begin
            step(vec[i], $sformatf("row%0d", i));
        end

        // counter saturates at 255 while hits keep coming
        for (int k = 0; k < 260; k++) begin
            step(io(0,0,1,1, 1,1,0, (3 + k > 255) ? 8'd255 : 8'(3 + k), 0),
                 $sformatf("sat%0d", k));
        end

        // asynchronous reset mid-run, away from any clock edge
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst busy",        {7'd0, busy},    8'd0);
        chk("arst done",        {7'd0, done},    8'd0);
        chk("arst match_count", match_count,     8'd0);
        chk("arst cfg_err",     {7'd0, cfg_err}, 8'd0);
        chk("arst match",       {7'd0, match},   8'd0);
        @(negedge clk);
        rstn = 1'b1;

        // config is back to 101/len 3: only the third bit of 1,0,1 hits
        step(io(1,0,0,0, 0,0,0,8'd0,0), "post0");
        step(io(0,0,1,1, 0,1,0,8'd0,0), "post1");
        step(io(0,0,1,0, 0,1,0,8'd0,0), "post2");
        step(io(0,0,1,1, 1,1,0,8'd0,0), "post3");
        step(io(0,0,0,0, 0,1,0,8'd1,0), "post4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
